// File: rtl/apb_cmd_master_if.sv
// Command/response handshake and APB bus bundle
// for the single-transfer APB requester.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB requester: one command at a time through
// IDLE -> SETUP -> ACCESS, with optional wait timeout.
module apb_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb_cmd_master_if.master      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    // saturating so a disabled timeout never wraps
    cnt_inc = (cnt_q == '1) ? cnt_q
                            : cnt_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d     = S_SETUP;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_write ? bus.cmd_wdata
                                      : '0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (bus.pready) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
        end else begin
          cnt_d = cnt_inc;
          if (TIMEOUT != 0 && cnt_inc == TO_V) begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed table, corner
// sequences and random commands against a memory model.
module tb_apb_cmd_master;

  localparam int TO = 4;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  apb_cmd_master_if #(.ADDR_W(8), .DATA_W(8)) bus();

  apb_cmd_master #(
    .ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  bit         rnd_mode   = 1'b0;
  logic       rnd_pready = 1'b0;
  logic [7:0] rnd_prdata = 8'h00;
  int         wait_cfg   = 0;
  int         acc_cnt    = 0;
  logic [7:0] smem [256];
  bit         init_done  = 1'b0;

  // simple APB slave: memory plus programmable wait states
  always @(posedge pclk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
      smem[5]   <= 8'h3C;
      init_done <= 1'b1;
    end else if (bus.psel && bus.penable &&
                 bus.pready && bus.pwrite) begin
      smem[bus.paddr] <= bus.pwdata;
    end
    if (bus.psel && bus.penable && !bus.pready)
      acc_cnt <= acc_cnt + 1;
    else if (!bus.penable)
      acc_cnt <= 0;
  end

  assign bus.pready = rnd_mode ? rnd_pready
                               : (acc_cnt >= wait_cfg);
  assign bus.prdata = rnd_mode ? rnd_prdata
                               : smem[bus.paddr];

  typedef struct {
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    int         waits;
    bit         err;
    logic [7:0] rd;
  } vec_t;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic run_cmd(input bit w,
                         input logic [7:0] a,
                         input logic [7:0] d,
                         input int waits,
                         input bit exp_err,
                         input logic [7:0] exp_rd);
    int         acc;
    bit         done;
    logic [7:0] ewd;
    ewd      = w ? d : 8'h00;
    wait_cfg = waits;
    chk("idle_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = 8'($urandom);
    chk("setup",
        {bus.cmd_ready, bus.psel, bus.penable,
         bus.pwrite, bus.paddr, bus.pwdata},
        {1'b0, 1'b1, 1'b0, w, a, ewd});
    acc  = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      bus.cmd_addr  = 8'($urandom);
      bus.cmd_wdata = 8'($urandom);
      if (bus.rsp_valid) begin
        done = 1'b1;
      end else begin
        acc++;
        chk("access",
            {bus.psel, bus.penable, bus.pwrite,
             bus.paddr, bus.pwdata},
            {1'b1, 1'b1, w, a, ewd});
      end
    end
    chk("rsp_seen", done, 1);
    chk("acc_cycles", acc, exp_err ? TO : waits + 1);
    chk("rsp",
        {bus.rsp_err, bus.rsp_rdata, bus.psel,
         bus.penable, bus.cmd_ready},
        {exp_err, exp_rd, 1'b0, 1'b0, 1'b1});
    tick();
    chk("rsp_pulse",
        {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err},
        {1'b0, exp_rd, exp_err});
  endtask

  vec_t       tbl [6];
  logic [7:0] mm  [8];
  logic [7:0] ba  [3];
  logic [7:0] bd  [3];
  bit         bw  [3];
  logic [7:0] bex [3];

  initial begin
    tbl[0] = '{1'b1, 8'h03, 8'hA5, 0,  1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h03, 8'h00, 0,  1'b0, 8'hA5};
    tbl[2] = '{1'b0, 8'h05, 8'h00, 3,  1'b0, 8'h3C};
    tbl[3] = '{1'b1, 8'h07, 8'h99, 10, 1'b1, 8'h00};
    tbl[4] = '{1'b1, 8'h07, 8'h5A, 0,  1'b0, 8'h00};
    tbl[5] = '{1'b0, 8'h07, 8'h00, 2,  1'b0, 8'h5A};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    preset = 1'b1;
    tick();
    tick();
    chk("reset_out",
        {bus.cmd_ready, bus.rsp_valid, bus.rsp_err,
         bus.rsp_rdata, bus.psel, bus.penable,
         bus.pwrite, bus.paddr, bus.pwdata},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 8'h00, 8'h00});
    preset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_cmd(tbl[i].w, tbl[i].a, tbl[i].d,
              tbl[i].waits, tbl[i].err, tbl[i].rd);

    // bus noise while idle must not start anything
    rnd_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rnd_pready = 1'($urandom);
      rnd_prdata = 8'($urandom);
      tick();
      chk("idle_quiet",
          {bus.psel, bus.penable, bus.rsp_valid},
          3'b000);
    end
    rnd_mode = 1'b0;
    chk("rdata_hold", bus.rsp_rdata, 8'h5A);

    // back-to-back with garbage while busy
    bw[0] = 1'b1; ba[0] = 8'h40; bd[0] = 8'h11;
    bw[1] = 1'b1; ba[1] = 8'h41; bd[1] = 8'h22;
    bw[2] = 1'b0; ba[2] = 8'h40; bd[2] = 8'h77;
    bex[0] = 8'h00; bex[1] = 8'h00; bex[2] = 8'h11;
    wait_cfg = 0;
    begin
      int k, nrsp, last_acc;
      k = 0; nrsp = 0; last_acc = -1;
      for (int c = 0; c < 30 && nrsp < 3; c++) begin
        if (bus.cmd_ready && k < 3) begin
          if (k > 0) chk("b2b_space", c - last_acc, 3);
          last_acc = c;
          bus.cmd_valid = 1'b1;
          bus.cmd_write = bw[k];
          bus.cmd_addr  = ba[k];
          bus.cmd_wdata = bd[k];
          k++;
        end else begin
          bus.cmd_valid = (k < 3);
          bus.cmd_write = 1'($urandom);
          bus.cmd_addr  = 8'($urandom);
          bus.cmd_wdata = 8'($urandom);
        end
        tick();
        if (bus.psel)
          chk("b2b_bus", {bus.paddr, bus.pwdata},
              {ba[k-1], bw[k-1] ? bd[k-1] : 8'h00});
        if (bus.rsp_valid) begin
          chk("b2b_rsp", {bus.rsp_err, bus.rsp_rdata},
              {1'b0, bex[nrsp]});
          nrsp++;
        end
      end
      chk("b2b_count", {k[7:0], nrsp[7:0]}, 16'h0303);
      bus.cmd_valid = 1'b0;
    end
    tick();

    // reset in the middle of ACCESS
    wait_cfg      = 100;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h09;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("pre_rst_access", {bus.psel, bus.penable}, 2'b11);
    preset = 1'b1;
    tick();
    chk("rst_mid1",
        {bus.psel, bus.penable, bus.rsp_valid,
         bus.cmd_ready}, 4'b0001);
    tick();
    chk("rst_mid2",
        {bus.psel, bus.penable, bus.rsp_valid,
         bus.cmd_ready}, 4'b0001);
    preset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_no_rsp", {bus.psel, bus.rsp_valid}, 2'b00);
    end

    // random commands against a memory model
    for (int i = 0; i < 8; i++) mm[i] = 8'h00;
    for (int n = 0; n < 40; n++) begin
      bit         w, e;
      int         wt, ai;
      logic [7:0] d, exp_rd;
      w  = 1'($urandom);
      ai = int'($urandom_range(0, 7));
      d  = 8'($urandom);
      wt = int'($urandom_range(0, 5));
      e  = (wt >= TO);
      exp_rd = 8'h00;
      if (!e) begin
        if (w) mm[ai] = d;
        else   exp_rd = mm[ai];
      end
      run_cmd(w, 8'h20 + 8'(ai), d, wt, e, exp_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
